// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the rf write port between writeback and a FIFO of multi-cycle results,
// with a starvation guard that requests a writeback bubble and a per-register pending mask.
module rf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_wen,
    input  logic [4:0]  i_wb_waddr,
    input  logic [31:0] i_wb_wdata,
    input  logic        i_mc_valid,
    output logic        o_mc_ready,
    input  logic [4:0]  i_mc_waddr,
    input  logic [31:0] i_mc_wdata,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_rd_wdata,
    output logic [31:0] o_pend_mask,
    output logic        o_wb_stall,
    output logic        o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d, err_q, err_d;
    logic          empty, push, pop;

    // Writeback always wins the port; a stall only makes the pipeline leave it free.
    always_comb begin
        empty      = count_q == '0;
        o_mc_ready = count_q < CW'(DEPTH);
        push       = i_mc_valid && o_mc_ready && (i_mc_waddr != 5'd0);
        pop        = !i_wb_wen && !empty;
        o_rd_wen   = i_wb_wen || !empty;
        o_rd_waddr = i_wb_wen ? i_wb_waddr : (empty ? 5'd0 : addr_q[rd_ptr_q]);
        o_rd_wdata = i_wb_wen ? i_wb_wdata : (empty ? 32'd0 : data_q[rd_ptr_q]);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        wait_d     = (empty || pop) ? '0 : (wait_q == WW'(STARVE_LIMIT) ? wait_q : wait_q + WW'(1));
        stall_d    = wait_d >= WW'(STARVE_LIMIT);
        err_d      = err_q || (stall_q && i_wb_wen);
        o_wb_stall = stall_q;
        o_err      = err_q;
    end

    always_comb begin
        o_pend_mask = '0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) o_pend_mask[addr_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= i_mc_waddr;
            data_q[wr_ptr_q] <= i_mc_wdata;
        end
    end
endmodule
